// File: rtl/tt_ram_pkg.sv
// ============================================================================
// Module      : tt_ram_pkg
// Description : Shared definitions for the SRAM sense-amp sequencer. Holds
//               the sequencer state encoding, the address and counter width
//               helpers, and the elaboration-time parameter legality checks.
// Macros      : none
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tt_ram_pkg;

    // Narrowest state counter. The runtime sense trim is 4 bits wide, so the
    // counter must be able to hold a full trim value.
    localparam int c_CNT_W_MIN = 4;
    localparam int c_TRIM_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PCH     = 3'd1,
        ST_EVAL    = 3'd2,
        ST_SENSE   = 3'd3,
        ST_WRITE   = 3'd4,
        ST_RECOVER = 3'd5
    } state_e;

    function automatic int f_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Index width of a decoder; a single-output decoder still has a 1-bit index.
    function automatic int f_idx_w(input int n);
        return (f_clog2(n) < 1) ? 1 : f_clog2(n);
    endfunction

    // Request address width: row bits above column bits.
    function automatic int f_addr_w(input int rows, input int mux);
        return f_clog2(rows) + f_clog2(mux);
    endfunction

    // Counter width covers the longest programmed state duration.
    function automatic int f_cnt_w(input int a, input int b, input int c);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = f_clog2(m + 1);
        if (w < c_CNT_W_MIN) w = c_CNT_W_MIN;
        return w;
    endfunction

    function automatic bit f_is_pow2(input int v);
        return (v >= 1) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit f_params_ok(input int rows, input int mux, input int w,
                                       input int pch, input int sae, input int wr);
        return f_is_pow2(rows) && (rows >= 2) && f_is_pow2(mux) &&
               (w >= 1) && (pch >= 1) && (sae >= 1) && (wr >= 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tt_ram_onehot_dec.sv
// ============================================================================
// Module      : tt_ram_onehot_dec
// Description : Binary to one-hot decoder with enable. All outputs are low
//               when en is low, so the result is always one-hot or all-zero.
// Ports       : en     - decoder enable
//               idx    - binary index
//               onehot - decoded one-hot vector
// Macros      : none
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_ram_onehot_dec #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          en,
    input  logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign onehot[i] = en && (idx == IW'(i));
    end

endmodule

`default_nettype wire

// File: rtl/tt_ram_sa_sequencer.sv
// ============================================================================
// Module      : tt_ram_sa_sequencer
// Description : Read/write sequencer for an SRAM bitcell array sensed by
//               differential sense amplifiers. Accepts single-word requests
//               on a valid/ready handshake and drives precharge, wordline,
//               column select, sense enable and write drivers, capturing the
//               sense-amp outputs into a registered read-data port.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               req_valid/req_ready - request handshake
//               req_we/addr/wdata   - request fields, addr = {row, col}
//               rdata, rvalid       - read data and its one-cycle strobe
//               pch_en, wl, col_sel - precharge, one-hot wordline, column mux
//               sae, we_drv, din_drv- sense enable and write drivers
//               sa_out              - sense-amp outputs
//               sae_trim            - runtime sense delay (optional)
// Macros      : TT_RAM_SAE_TRIM_EN - adds sae_trim; the sense delay becomes
//               the value sampled at accept, with 0 treated as 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_ram_sa_sequencer
    import tt_ram_pkg::*;
#(
    parameter int ROWS    = 16,
    parameter int MUX     = 4,
    parameter int W       = 8,
    parameter int PCH_CYC = 2,
    parameter int SAE_DLY = 3,
    parameter int WR_CYC  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_we,
    input  logic [f_addr_w(ROWS,MUX)-1:0]  req_addr,
    input  logic [W-1:0]                   req_wdata,
    output logic [W-1:0]                   rdata,
    output logic                           rvalid,
    output logic                           pch_en,
    output logic [ROWS-1:0]                wl,
    output logic [MUX-1:0]                 col_sel,
    output logic                           sae,
    output logic                           we_drv,
    output logic [W-1:0]                   din_drv,
    input  logic [W-1:0]                   sa_out
`ifdef TT_RAM_SAE_TRIM_EN
    ,
    input  logic [c_TRIM_W-1:0]            sae_trim
`endif
);

    localparam int c_RW    = f_clog2(ROWS);
    localparam int c_CW    = f_clog2(MUX);
    localparam int c_AW    = c_RW + c_CW;
    localparam int c_CIW   = f_idx_w(MUX);
    localparam int c_CNT_W = f_cnt_w(PCH_CYC, SAE_DLY, WR_CYC);

    if (!f_params_ok(ROWS, MUX, W, PCH_CYC, SAE_DLY, WR_CYC)) begin : g_param_check
        $error("tt_ram_sa_sequencer: illegal parameter set");
    end

    state_e             r_state_q, w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic               r_we_q,    w_we_d;
    logic [c_RW-1:0]    r_row_q,   w_row_d;
    logic [c_CIW-1:0]   r_col_q,   w_col_d;
    logic [W-1:0]       r_wdata_q, w_wdata_d;
    logic [W-1:0]       r_rdata_q, w_rdata_d;

    logic [c_RW-1:0]    w_req_row;
    logic [c_CIW-1:0]   w_req_col;
    logic [c_CNT_W-1:0] w_eval_reload;
    logic               w_wl_en;
    logic               w_col_en;

    assign w_req_row = req_addr[c_AW-1 -: c_RW];

    if (c_CW > 0) begin : g_col_field
        assign w_req_col = req_addr[c_CW-1:0];
    end else begin : g_col_none
        assign w_req_col = '0;
    end

    // The counter holds "cycles remaining minus one" and reloads on every
    // state entry, so a state exits on the cycle it reads zero.
`ifdef TT_RAM_SAE_TRIM_EN
    logic [c_TRIM_W-1:0] r_trim_q, w_trim_d;
    assign w_eval_reload = (r_trim_q == '0) ? '0 : c_CNT_W'(r_trim_q - 4'd1);
`else
    assign w_eval_reload = c_CNT_W'(SAE_DLY - 1);
`endif

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_we_d    = r_we_q;
        w_row_d   = r_row_q;
        w_col_d   = r_col_q;
        w_wdata_d = r_wdata_q;
        w_rdata_d = r_rdata_q;
`ifdef TT_RAM_SAE_TRIM_EN
        w_trim_d  = r_trim_q;
`endif
        case (r_state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    w_we_d    = req_we;
                    w_row_d   = w_req_row;
                    w_col_d   = w_req_col;
                    w_wdata_d = req_wdata;
`ifdef TT_RAM_SAE_TRIM_EN
                    w_trim_d  = sae_trim;
`endif
                    w_state_d = ST_PCH;
                    w_cnt_d   = c_CNT_W'(PCH_CYC - 1);
                end
            end
            ST_PCH: begin
                if (r_cnt_q != '0) begin
                    w_cnt_d = r_cnt_q - c_CNT_W'(1);
                end else if (r_we_q) begin
                    w_state_d = ST_WRITE;
                    w_cnt_d   = c_CNT_W'(WR_CYC - 1);
                end else begin
                    w_state_d = ST_EVAL;
                    w_cnt_d   = w_eval_reload;
                end
            end
            ST_EVAL: begin
                if (r_cnt_q != '0) begin
                    w_cnt_d = r_cnt_q - c_CNT_W'(1);
                end else begin
                    w_state_d = ST_SENSE;
                    w_cnt_d   = '0;
                end
            end
            ST_SENSE: begin
                w_rdata_d = sa_out;
                w_state_d = ST_RECOVER;
                w_cnt_d   = '0;
            end
            ST_WRITE: begin
                if (r_cnt_q != '0) begin
                    w_cnt_d = r_cnt_q - c_CNT_W'(1);
                end else begin
                    w_state_d = ST_RECOVER;
                    w_cnt_d   = '0;
                end
            end
            ST_RECOVER: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
            end
            default: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= '0;
            r_we_q    <= 1'b0;
            r_row_q   <= '0;
            r_col_q   <= '0;
            r_wdata_q <= '0;
            r_rdata_q <= '0;
`ifdef TT_RAM_SAE_TRIM_EN
            r_trim_q  <= '0;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_we_q    <= w_we_d;
            r_row_q   <= w_row_d;
            r_col_q   <= w_col_d;
            r_wdata_q <= w_wdata_d;
            r_rdata_q <= w_rdata_d;
`ifdef TT_RAM_SAE_TRIM_EN
            r_trim_q  <= w_trim_d;
`endif
        end
    end

    // Strobes decode straight from the state, so precharge and wordline can
    // never overlap and every strobe is low in IDLE.
    assign req_ready = (r_state_q == ST_IDLE) && !rst;
    assign pch_en    = (r_state_q == ST_PCH);
    assign sae       = (r_state_q == ST_SENSE);
    assign we_drv    = (r_state_q == ST_WRITE);
    assign din_drv   = we_drv ? r_wdata_q : '0;
    assign rvalid    = (r_state_q == ST_RECOVER) && !r_we_q;
    assign rdata     = r_rdata_q;
    assign w_wl_en   = (r_state_q == ST_EVAL) || (r_state_q == ST_SENSE) ||
                       (r_state_q == ST_WRITE);
    assign w_col_en  = (r_state_q != ST_IDLE);

    tt_ram_onehot_dec #(
        .N  (ROWS),
        .IW (c_RW)
    ) u_wl_dec (
        .en     (w_wl_en),
        .idx    (r_row_q),
        .onehot (wl)
    );

    tt_ram_onehot_dec #(
        .N  (MUX),
        .IW (c_CIW)
    ) u_col_dec (
        .en     (w_col_en),
        .idx    (r_col_q),
        .onehot (col_sel)
    );

endmodule

`default_nettype wire

// File: tb/tb_tt_ram_sa_sequencer.sv
// ============================================================================
// Module      : tb_tt_ram_sa_sequencer
// Description : Self-checking bench for tt_ram_sa_sequencer with default
//               parameters. A cycle-frame model predicts every output each
//               cycle; directed tests pin the model with literal values.
// Macros      : TT_RAM_SAE_TRIM_EN - connects sae_trim and adds trim tests
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_ram_sa_sequencer;

    localparam int ROWS    = 16;
    localparam int MUX     = 4;
    localparam int W       = 8;
    localparam int PCH_CYC = 2;
    localparam int SAE_DLY = 3;
    localparam int WR_CYC  = 2;
    localparam int AW      = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_we = 1'b0;
    logic [AW-1:0]   req_addr = '0;
    logic [W-1:0]    req_wdata = '0;
    logic [W-1:0]    sa_out = '0;
    logic            req_ready;
    logic [W-1:0]    rdata;
    logic            rvalid;
    logic            pch_en;
    logic [ROWS-1:0] wl;
    logic [MUX-1:0]  col_sel;
    logic            sae;
    logic            we_drv;
    logic [W-1:0]    din_drv;
`ifdef TT_RAM_SAE_TRIM_EN
    logic [3:0]      sae_trim = 4'd3;
`endif

    int checks   = 0;
    int failures = 0;

    tt_ram_sa_sequencer #(
        .ROWS(ROWS), .MUX(MUX), .W(W),
        .PCH_CYC(PCH_CYC), .SAE_DLY(SAE_DLY), .WR_CYC(WR_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .pch_en    (pch_en),
        .wl        (wl),
        .col_sel   (col_sel),
        .sae       (sae),
        .we_drv    (we_drv),
        .din_drv   (din_drv),
        .sa_out    (sa_out)
`ifdef TT_RAM_SAE_TRIM_EN
        ,
        .sae_trim  (sae_trim)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: one frame per busy cycle ----------
    typedef struct {
        bit          pch;
        int          row;
        bit          sae;
        bit          we;
        logic [W-1:0] din;
        bit          rv;
        int          col;
    } frame_t;

    frame_t       q[$];
    logic [W-1:0] m_rdata = '0;
    bit           started = 1'b0;
    int           cyc = 0;
    int           dut_acc[$];

    function automatic frame_t mk(bit pch, int row, bit s, bit we, logic [W-1:0] din, bit rv, int col);
        frame_t f;
        f.pch = pch; f.row = row; f.sae = s; f.we = we; f.din = din; f.rv = rv; f.col = col;
        return f;
    endfunction

    function automatic void model_accept(bit we, logic [AW-1:0] a, logic [W-1:0] wd, int d);
        int row;
        int col;
        row = int'(a) / MUX;
        col = int'(a) % MUX;
        for (int i = 0; i < PCH_CYC; i++) q.push_back(mk(1, -1, 0, 0, '0, 0, col));
        if (we) begin
            for (int i = 0; i < WR_CYC; i++) q.push_back(mk(0, row, 0, 1, wd, 0, col));
            q.push_back(mk(0, -1, 0, 0, '0, 0, col));
        end else begin
            for (int i = 0; i < d; i++) q.push_back(mk(0, row, 0, 0, '0, 0, col));
            q.push_back(mk(0, row, 1, 0, '0, 0, col));
            q.push_back(mk(0, -1, 0, 0, '0, 1, col));
        end
    endfunction

    initial begin
        int d;
        forever begin
            @(posedge clk);
            cyc++;
            if (req_valid && req_ready && !rst) dut_acc.push_back(cyc);
            started = 1'b1;
            if (rst) begin
                q.delete();
                m_rdata = '0;
            end else if (q.size() != 0) begin
                if (q[0].sae) m_rdata = sa_out;
                void'(q.pop_front());
            end else if (req_valid) begin
`ifdef TT_RAM_SAE_TRIM_EN
                d = (sae_trim == 4'd0) ? 1 : int'(sae_trim);
`else
                d = SAE_DLY;
`endif
                model_accept(req_we, req_addr, req_wdata, d);
            end
        end
    end

    // Compare every cycle, a little after the active edge.
    initial begin
        frame_t f;
        bit     busy;
        forever begin
            @(posedge clk);
            #3;
            if (started) begin
                busy = (q.size() != 0);
                f = busy ? q[0] : mk(0, -1, 0, 0, '0, 0, -1);
                chk("req_ready", req_ready, (!busy && !rst));
                chk("pch_en",    pch_en,    f.pch);
                chk("wl",        wl,        (f.row >= 0) ? (64'd1 << f.row) : 64'd0);
                chk("col_sel",   col_sel,   (f.col >= 0) ? (64'd1 << f.col) : 64'd0);
                chk("sae",       sae,       f.sae);
                chk("we_drv",    we_drv,    f.we);
                chk("din_drv",   din_drv,   f.we ? f.din : '0);
                chk("rvalid",    rvalid,    f.rv);
                chk("rdata",     rdata,     m_rdata);
                chk("pch_wl_overlap", (pch_en && (wl != '0)), 1'b0);
            end
        end
    end

    // ---------------- directed stimulus -------------------------------------
    logic            rec_pch [0:15];
    logic [ROWS-1:0] rec_wl  [0:15];
    logic [MUX-1:0]  rec_col [0:15];
    logic            rec_sae [0:15];
    logic            rec_we  [0:15];
    logic [W-1:0]    rec_din [0:15];
    logic            rec_rv  [0:15];
    logic [W-1:0]    rec_rd  [0:15];
    logic            rec_rdy [0:15];

    // Presents a request at a negedge, waits for acceptance, and returns at
    // the negedge of the first cycle after the accept edge.
    task automatic send(input bit we, input logic [AW-1:0] a, input logic [W-1:0] wd,
                        input logic [W-1:0] sa);
        bit ok;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; sa_out = sa;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL accept_timeout actual=no_ready required=ready time=%0t", $time);
        end
        @(negedge clk);
        req_valid = 1'b0; req_we = ~we; req_addr = ~a; req_wdata = ~wd;
    endtask

    task automatic record(input int n);
        for (int i = 0; i < n; i++) begin
            rec_pch[i] = pch_en; rec_wl[i] = wl; rec_col[i] = col_sel; rec_sae[i] = sae;
            rec_we[i] = we_drv; rec_din[i] = din_drv; rec_rv[i] = rvalid; rec_rd[i] = rdata;
            rec_rdy[i] = req_ready;
            @(negedge clk);
        end
    endtask

    function automatic int first_ready(input int n);
        for (int i = 0; i < n; i++) if (rec_rdy[i]) return i;
        return -1;
    endfunction

    function automatic int count_wl(input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) if (rec_wl[i] != '0) c++;
        return c;
    endfunction

    initial begin
        int c_pch, c_wl, c_sae, n_sae, c_rv, c_col, c_wr, s0;
        bit ok;
        logic            t_we [0:4];
        logic [AW-1:0]   t_a  [0:4];
        logic [W-1:0]    t_d  [0:4];

        // Reset for three cycles, then release.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready",   req_ready, 1'b0);
        chk("rst_strobes", {pch_en, sae, we_drv, rvalid, (wl != '0), (col_sel != '0), (din_drv != '0)}, 7'd0);
        chk("rst_rdata",   rdata, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready",   req_ready, 1'b1);
        chk("post_rst_strobes", {pch_en, sae, we_drv, rvalid, (wl != '0), (col_sel != '0)}, 6'd0);

        // Reset mid-EVAL: read aborted, rdata stays 0.
        send(1'b0, 6'h13, 8'h00, 8'hFF);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (wl != '0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("mid_eval_reached", ok, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_strobes", {pch_en, sae, we_drv, rvalid, (wl != '0), (col_sel != '0), (din_drv != '0)}, 7'd0);
        chk("mid_rst_rdata", rdata, 8'h00);
        rst = 1'b0;
        record(10);
        c_rv = 0;
        for (int i = 0; i < 10; i++) if (rec_rv[i]) c_rv++;
        chk("mid_rst_no_rvalid", c_rv, 0);
        chk("mid_rst_rdata_after", rec_rd[9], 8'h00);

        // Read addr 0x2D (row 11, col 1), sa_out 0xA5.
        send(1'b0, 6'h2D, 8'h00, 8'hA5);
        record(10);
        c_pch = 0; c_wl = 0; c_sae = 0; n_sae = -1; c_rv = 0; c_col = 0;
        for (int i = 0; i < 10; i++) begin
            if (rec_pch[i]) c_pch++;
            if (rec_wl[i] == 16'h0800) c_wl++;
            if (rec_sae[i]) begin c_sae++; n_sae = i; end
            if (rec_rv[i]) c_rv++;
            if (i <= 6 && rec_col[i] == 4'b0010) c_col++;
        end
        chk("rd_pch_cycles", c_pch, 2);
        chk("rd_pch_first",  rec_pch[0], 1'b1);
        chk("rd_wl11_cycles", c_wl, 4);
        chk("rd_wl_total",   count_wl(10), 4);
        chk("rd_wl_start",   rec_wl[2], 16'h0800);
        chk("rd_sae_count",  c_sae, 1);
        chk("rd_sae_cycle",  n_sae, 5);
        chk("rd_rvalid_n6",  rec_rv[6], 1'b1);
        chk("rd_rvalid_cnt", c_rv, 1);
        chk("rd_rdata",      rec_rd[6], 8'hA5);
        chk("rd_col_sel",    c_col, 7);
        chk("rd_ready_back", first_ready(10), 7);

        // Write addr 0x00, wdata 0x3C.
        send(1'b1, 6'h00, 8'h3C, 8'h00);
        record(8);
        c_wr = 0; c_rv = 0;
        for (int i = 0; i < 8; i++) begin
            if (rec_we[i] && rec_din[i] == 8'h3C && rec_wl[i] == 16'h0001) c_wr++;
            if (rec_rv[i]) c_rv++;
        end
        chk("wr_pulse_cycles", c_wr, 2);
        chk("wr_no_rvalid",    c_rv, 0);
        chk("wr_ready_back",   first_ready(8), 5);
        chk("wr_rdata_kept",   rec_rd[7], 8'hA5);
        chk("wr_din_outside",  rec_din[6], 8'h00);

        // Back-to-back reads with req_valid held.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'h07; sa_out = 8'h5A;
        s0 = dut_acc.size();
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dut_acc.size() >= s0 + 2) begin ok = 1'b1; break; end
        end
        req_valid = 1'b0;
        chk("b2b_two_accepts", ok, 1'b1);
        if (ok) chk("b2b_period", dut_acc[s0 + 1] - dut_acc[s0], PCH_CYC + SAE_DLY + 3);
        repeat (12) @(negedge clk);
        chk("b2b_rdata", rdata, 8'h5A);

        // Mixed operations checked by the model.
        t_we[0] = 1'b1; t_a[0] = 6'h3F; t_d[0] = 8'h81;
        t_we[1] = 1'b0; t_a[1] = 6'h3F; t_d[1] = 8'h7E;
        t_we[2] = 1'b1; t_a[2] = 6'h10; t_d[2] = 8'hFF;
        t_we[3] = 1'b0; t_a[3] = 6'h01; t_d[3] = 8'h00;
        t_we[4] = 1'b0; t_a[4] = 6'h22; t_d[4] = 8'hC3;
        for (int k = 0; k < 5; k++) begin
            send(t_we[k], t_a[k], t_d[k], t_we[k] ? 8'h99 : t_d[k]);
            repeat (12) @(negedge clk);
        end
        chk("mix_last_rdata", rdata, 8'hC3);

`ifdef TT_RAM_SAE_TRIM_EN
        // Trim 0 behaves as 1 EVAL cycle.
        sae_trim = 4'd0;
        send(1'b0, 6'h05, 8'h00, 8'h11);
        record(14);
        chk("trim0_eval_cycles", count_wl(14) - 1, 1);
        // Trim 7; changing it mid-operation has no effect.
        sae_trim = 4'd7;
        send(1'b0, 6'h06, 8'h00, 8'h22);
        sae_trim = 4'd15;
        record(14);
        chk("trim7_eval_cycles", count_wl(14) - 1, 7);
        chk("trim7_rdata", rdata, 8'h22);
        sae_trim = 4'd3;
`endif

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
